// File: rtl/rmt_restore_engine.sv
// Write-side initiator for the rename-map SRAM: identity fill after reset, AMT-to-RMT restore copy,
// and rename-stage write passthrough while idle.
module rmt_restore_engine #(
  parameter int NUM_ENTRIES = 32,
  parameter int SRAM_INDEX  = 5,
  parameter int SRAM_WIDTH  = 7,
  parameter int WR_PORTS    = 6
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           restore_i,
  input  logic [WR_PORTS-1:0]            norm_we_i,
  input  logic [WR_PORTS*SRAM_INDEX-1:0] norm_addr_i,
  input  logic [WR_PORTS*SRAM_WIDTH-1:0] norm_data_i,
  output logic [WR_PORTS*SRAM_INDEX-1:0] amt_addr_o,
  input  logic [WR_PORTS*SRAM_WIDTH-1:0] amt_data_i,
  output logic [WR_PORTS-1:0]            we_o,
  output logic [WR_PORTS*SRAM_INDEX-1:0] addr_wr_o,
  output logic [WR_PORTS*SRAM_WIDTH-1:0] data_wr_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [1:0]                     dbg_state
);

  localparam int G  = (NUM_ENTRIES + WR_PORTS - 1) / WR_PORTS;
  localparam int GW = (G > 1) ? $clog2(G) : 1;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_COPY, S_DRAIN} state_t;

  state_t                         state, state_nxt;
  logic [GW-1:0]                  grp, grp_nxt;
  logic                           pending, pending_nxt;
  logic                           done_q, done_nxt;
  logic [WR_PORTS-1:0]            pipe_we;
  logic [WR_PORTS*SRAM_INDEX-1:0] pipe_addr;
  logic [WR_PORTS*SRAM_WIDTH-1:0] pipe_data;
  logic [WR_PORTS-1:0]            lane_ok;
  logic [WR_PORTS*SRAM_INDEX-1:0] grp_addr;
  logic [WR_PORTS*SRAM_WIDTH-1:0] grp_data;
  logic [WR_PORTS*SRAM_WIDTH-1:0] amt_masked;
  logic                           last_grp;

  assign last_grp  = (grp == GW'(G - 1));
  assign dbg_state = state;

  // Entry numbers of the current group; lanes past the end of the table stay disabled with zero fields.
  always_comb begin
    lane_ok    = '0;
    grp_addr   = '0;
    grp_data   = '0;
    amt_masked = '0;
    for (int k = 0; k < WR_PORTS; k++) begin
      logic [31:0] e;
      e = 32'(grp) * 32'(WR_PORTS) + 32'(k);
      if (e < 32'(NUM_ENTRIES)) begin
        lane_ok[k] = 1'b1;
        grp_addr[k*SRAM_INDEX +: SRAM_INDEX] = e[SRAM_INDEX-1:0];
        grp_data[k*SRAM_WIDTH +: SRAM_WIDTH] = e[SRAM_WIDTH-1:0];
        amt_masked[k*SRAM_WIDTH +: SRAM_WIDTH] = amt_data_i[k*SRAM_WIDTH +: SRAM_WIDTH];
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    grp_nxt     = grp;
    pending_nxt = pending;
    done_nxt    = 1'b0;
    case (state)
      S_INIT: begin
        pending_nxt = pending | restore_i;
        grp_nxt     = grp + GW'(1);
        if (last_grp) begin
          state_nxt = S_IDLE;
          grp_nxt   = '0;
          done_nxt  = 1'b1;
        end
      end
      S_IDLE: begin
        if (restore_i || pending) begin
          state_nxt   = S_COPY;
          grp_nxt     = '0;
          pending_nxt = 1'b0;
        end
      end
      S_COPY: begin
        pending_nxt = pending | restore_i;
        grp_nxt     = grp + GW'(1);
        if (last_grp) begin
          state_nxt = S_DRAIN;
          grp_nxt   = '0;
        end
      end
      S_DRAIN: begin
        pending_nxt = pending | restore_i;
        state_nxt   = S_IDLE;
        done_nxt    = 1'b1;
      end
      default: state_nxt = S_INIT;
    endcase
  end

  // Reset masks every output immediately so an aborted operation writes nothing in the reset cycle.
  always_comb begin
    we_o       = '0;
    addr_wr_o  = '0;
    data_wr_o  = '0;
    amt_addr_o = '0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    if (!reset) begin
      done_o = done_q;
      case (state)
        S_INIT: begin
          busy_o    = 1'b1;
          we_o      = lane_ok;
          addr_wr_o = grp_addr;
          data_wr_o = grp_data;
        end
        S_IDLE: begin
          we_o      = norm_we_i;
          addr_wr_o = norm_addr_i;
          data_wr_o = norm_data_i;
        end
        S_COPY: begin
          busy_o     = 1'b1;
          amt_addr_o = grp_addr;
          we_o       = pipe_we;
          addr_wr_o  = pipe_addr;
          data_wr_o  = pipe_data;
        end
        S_DRAIN: begin
          busy_o    = 1'b1;
          we_o      = pipe_we;
          addr_wr_o = pipe_addr;
          data_wr_o = pipe_data;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_INIT;
      grp       <= '0;
      pending   <= 1'b0;
      done_q    <= 1'b0;
      pipe_we   <= '0;
      pipe_addr <= '0;
      pipe_data <= '0;
    end else begin
      state   <= state_nxt;
      grp     <= grp_nxt;
      pending <= pending_nxt;
      done_q  <= done_nxt;
      // Pipe is empty outside COPY, so the first COPY cycle never writes.
      if (state == S_COPY) begin
        pipe_we   <= lane_ok;
        pipe_addr <= grp_addr;
        pipe_data <= amt_masked;
      end else begin
        pipe_we   <= '0;
        pipe_addr <= '0;
        pipe_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rmt_restore_engine.sv
// Directed bench for rmt_restore_engine with a behavioural rename-map SRAM and AMT alongside the DUT.
module tb_rmt_restore_engine;
  localparam int N = 32, IDX = 5, W = 7, P = 6;

  logic           clk = 1'b0;
  logic           reset, restore_i;
  logic [P-1:0]   norm_we_i;
  logic [P*IDX-1:0] norm_addr_i;
  logic [P*W-1:0] norm_data_i;
  logic [P*IDX-1:0] amt_addr_o;
  logic [P*W-1:0] amt_data_i;
  logic [P-1:0]   we_o;
  logic [P*IDX-1:0] addr_wr_o;
  logic [P*W-1:0] data_wr_o;
  logic           busy_o, done_o;
  logic [1:0]     dbg_state;

  logic [W-1:0] rmt [N];
  logic [W-1:0] amt_mem [N];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rmt_restore_engine #(.NUM_ENTRIES(N), .SRAM_INDEX(IDX), .SRAM_WIDTH(W), .WR_PORTS(P)) dut (
    .clk(clk), .reset(reset), .restore_i(restore_i), .norm_we_i(norm_we_i),
    .norm_addr_i(norm_addr_i), .norm_data_i(norm_data_i), .amt_addr_o(amt_addr_o),
    .amt_data_i(amt_data_i), .we_o(we_o), .addr_wr_o(addr_wr_o), .data_wr_o(data_wr_o),
    .busy_o(busy_o), .done_o(done_o), .dbg_state(dbg_state)
  );

  // Multi-port SRAM: higher lane wins on a shared address.
  always @(posedge clk) begin
    for (int k = 0; k < P; k++)
      if (we_o[k]) rmt[addr_wr_o[k*IDX +: IDX]] <= data_wr_o[k*W +: W];
  end

  always_comb begin
    amt_data_i = '0;
    for (int k = 0; k < P; k++) amt_data_i[k*W +: W] = amt_mem[amt_addr_o[k*IDX +: IDX]];
  end

  task automatic test_reset();
    reset = 1'b1; restore_i = 1'b0; norm_we_i = '0; norm_addr_i = '0; norm_data_i = '0;
    @(negedge clk); #1;
    checks++;
    if (we_o !== '0 || busy_o !== 1'b0 || done_o !== 1'b0 || amt_addr_o !== '0) begin
      errors++;
      $display("FAIL reset_outputs we=%b busy=%b done=%b amt_addr=%h, required all 0", we_o, busy_o, done_o, amt_addr_o);
    end
  endtask

  task automatic test_init_fill();
    int bad;
    @(negedge clk); reset = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      checks++;
      if (busy_o !== 1'b1) begin errors++; $display("FAIL init_busy cycle %0d busy=%b, required 1", c, busy_o); end
      checks++;
      if (we_o !== ((c == 6) ? 6'b000011 : 6'b111111)) begin
        errors++; $display("FAIL init_we cycle %0d we=%b", c, we_o);
      end
      if (c == 1) begin
        checks++;
        if (addr_wr_o[5*IDX +: IDX] !== 5'd5 || data_wr_o[5*W +: W] !== 7'd5 || addr_wr_o[0 +: IDX] !== 5'd0) begin
          errors++; $display("FAIL init_grp0 lane5 addr=%0d data=%0d, required 5/5", addr_wr_o[5*IDX +: IDX], data_wr_o[5*W +: W]);
        end
      end
      if (c == 6) begin
        checks++;
        if (addr_wr_o[0 +: IDX] !== 5'd30 || addr_wr_o[IDX +: IDX] !== 5'd31 ||
            data_wr_o[0 +: W] !== 7'd30 || data_wr_o[W +: W] !== 7'd31 || addr_wr_o[2*IDX +: 4*IDX] !== '0) begin
          errors++; $display("FAIL init_last_group addr=%h data=%h, required lanes 30,31", addr_wr_o, data_wr_o);
        end
      end
    end
    @(negedge clk); #1;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b1) begin errors++; $display("FAIL init_done busy=%b done=%b, required 0/1", busy_o, done_o); end
    @(negedge clk); #1;
    checks++;
    if (done_o !== 1'b0) begin errors++; $display("FAIL init_done_pulse done=%b, required 0", done_o); end
    bad = 0;
    for (int i = 0; i < N; i++) if (rmt[i] !== 7'(i)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL init_identity %0d entries wrong, rmt[31]=%0d required 31", bad, rmt[31]); end
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    norm_we_i = 6'b100001; norm_addr_i = '0; norm_data_i = '0;
    norm_addr_i[0 +: IDX] = 5'd3; norm_addr_i[5*IDX +: IDX] = 5'd9;
    norm_data_i[0 +: W] = 7'd5;   norm_data_i[5*W +: W] = 7'd7;
    #1;
    checks++;
    if (we_o !== norm_we_i || addr_wr_o !== norm_addr_i || data_wr_o !== norm_data_i || busy_o !== 1'b0) begin
      errors++; $display("FAIL passthrough we=%b addr=%h data=%h busy=%b, required %b %h %h 0", we_o, addr_wr_o, data_wr_o, busy_o, norm_we_i, norm_addr_i, norm_data_i);
    end
    @(negedge clk); norm_we_i = '0; norm_addr_i = '0; norm_data_i = '0; #1;
    checks++;
    if (rmt[3] !== 7'd5 || rmt[9] !== 7'd7 || we_o !== '0) begin
      errors++; $display("FAIL passthrough_write rmt[3]=%0d rmt[9]=%0d we=%b, required 5 7 0", rmt[3], rmt[9], we_o);
    end
  endtask

  task automatic test_restore();
    int bad;
    for (int i = 0; i < N; i++) amt_mem[i] = 7'(31 - i);
    @(negedge clk); restore_i = 1'b1; #1;
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL restore_req_cycle busy=%b, required 0", busy_o); end
    @(negedge clk); restore_i = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      checks++;
      if (busy_o !== 1'b1) begin errors++; $display("FAIL restore_busy cycle %0d busy=%b, required 1", c, busy_o); end
      if (c == 1) begin
        checks++;
        if (we_o !== '0 || amt_addr_o[0 +: IDX] !== 5'd0 || amt_addr_o[5*IDX +: IDX] !== 5'd5) begin
          errors++; $display("FAIL restore_first_copy we=%b amt_addr=%h, required we 0 lanes 0..5", we_o, amt_addr_o);
        end
      end
      if (c == 2) begin
        checks++;
        if (we_o !== 6'b111111 || addr_wr_o[0 +: IDX] !== 5'd0 || data_wr_o[0 +: W] !== 7'd31) begin
          errors++; $display("FAIL restore_grp0_write we=%b addr0=%0d data0=%0d, required 111111 0 31", we_o, addr_wr_o[0 +: IDX], data_wr_o[0 +: W]);
        end
      end
      if (c == 7) begin
        checks++;
        if (we_o !== 6'b000011 || addr_wr_o[0 +: IDX] !== 5'd30 || addr_wr_o[IDX +: IDX] !== 5'd31 ||
            data_wr_o[0 +: W] !== 7'd1 || data_wr_o[W +: W] !== 7'd0 || amt_addr_o !== '0) begin
          errors++; $display("FAIL restore_drain we=%b addr=%h data=%h amt_addr=%h, required 000011 30/31 1/0", we_o, addr_wr_o, data_wr_o, amt_addr_o);
        end
      end
    end
    @(negedge clk); #1;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b1) begin errors++; $display("FAIL restore_done busy=%b done=%b, required 0/1", busy_o, done_o); end
    @(negedge clk); #1;
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL restore_done_once done=%b busy=%b, required 0/0", done_o, busy_o); end
    bad = 0;
    for (int i = 0; i < N; i++) if (rmt[i] !== 7'(31 - i)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL restore_contents %0d entries wrong, rmt[0]=%0d required 31", bad, rmt[0]); end
  endtask

  task automatic test_pending();
    int done_cnt, bad;
    @(negedge clk); reset = 1'b1; #1;
    checks++;
    if (busy_o !== 1'b0 || we_o !== '0) begin errors++; $display("FAIL pending_reset busy=%b we=%b, required 0", busy_o, we_o); end
    @(negedge clk); reset = 1'b0;
    done_cnt = 0;
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) @(negedge clk);
      restore_i = (c == 3);
      #1;
      if (done_o === 1'b1) done_cnt++;
      if (c == 7) begin
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b1) begin errors++; $display("FAIL pending_idle busy=%b done=%b, required 0/1", busy_o, done_o); end
      end
      if (c == 8) begin
        checks++;
        if (busy_o !== 1'b1 || we_o !== '0) begin errors++; $display("FAIL pending_copy_start busy=%b we=%b, required 1/0", busy_o, we_o); end
      end
      if (c == 14) begin
        checks++;
        if (busy_o !== 1'b1 || we_o !== 6'b000011) begin errors++; $display("FAIL pending_drain busy=%b we=%b, required 1/000011", busy_o, we_o); end
      end
      if (c == 16) begin
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL pending_cleared busy=%b, required 0", busy_o); end
      end
    end
    restore_i = 1'b0;
    checks++;
    if (done_cnt != 2) begin errors++; $display("FAIL pending_done_count %0d, required 2", done_cnt); end
    bad = 0;
    for (int i = 0; i < N; i++) if (rmt[i] !== 7'(31 - i)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL pending_contents %0d entries wrong", bad); end
  endtask

  task automatic test_reset_abort();
    int bad;
    for (int i = 0; i < N; i++) amt_mem[i] = 7'(i) ^ 7'h2a;
    @(negedge clk); restore_i = 1'b1; #1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); restore_i = 1'b0; reset = (c == 3); #1;
      if (c == 2) begin
        checks++;
        if (we_o !== 6'b111111) begin errors++; $display("FAIL abort_copy_write we=%b, required 111111", we_o); end
      end
    end
    checks++;
    if (we_o !== '0 || busy_o !== 1'b0 || amt_addr_o !== '0) begin
      errors++; $display("FAIL abort_reset_cycle we=%b busy=%b amt_addr=%h, required 0", we_o, busy_o, amt_addr_o);
    end
    @(negedge clk); reset = 1'b0; #1;
    checks++;
    if (busy_o !== 1'b1 || we_o !== 6'b111111 || addr_wr_o[0 +: IDX] !== 5'd0 || data_wr_o[5*W +: W] !== 7'd5) begin
      errors++; $display("FAIL abort_init_restart busy=%b we=%b addr0=%0d data5=%0d, required 1 111111 0 5", busy_o, we_o, addr_wr_o[0 +: IDX], data_wr_o[5*W +: W]);
    end
    for (int c = 2; c <= 7; c++) begin @(negedge clk); #1; end
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL abort_init_done done=%b busy=%b, required 1/0", done_o, busy_o); end
    bad = 0;
    for (int i = 0; i < N; i++) if (rmt[i] !== 7'(i)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL abort_identity %0d entries wrong", bad); end
  endtask

  task automatic test_norm_drop();
    int bad;
    for (int i = 0; i < N; i++) amt_mem[i] = 7'(i * 3 + 1);
    @(negedge clk); restore_i = 1'b1; #1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      restore_i = 1'b0; norm_we_i = 6'b111111;
      for (int k = 0; k < P; k++) begin
        norm_addr_i[k*IDX +: IDX] = 5'd2;
        norm_data_i[k*W +: W] = 7'h55;
      end
      #1;
      if (c == 1) begin
        checks++;
        if (we_o !== '0) begin errors++; $display("FAIL drop_first_copy we=%b, required 0", we_o); end
      end
      if (c >= 2 && c <= 6) begin
        checks++;
        if (we_o !== 6'b111111 || data_wr_o[0 +: W] !== 7'((c - 2) * 6 * 3 + 1)) begin
          errors++; $display("FAIL drop_copy cycle %0d we=%b data0=%0d, required 111111 %0d", c, we_o, data_wr_o[0 +: W], (c - 2) * 18 + 1);
        end
      end
      if (c == 7) begin
        checks++;
        if (we_o !== 6'b000011 || data_wr_o[0 +: W] !== 7'd91 || data_wr_o[W +: W] !== 7'd94) begin
          errors++; $display("FAIL drop_drain we=%b data=%h, required 000011 91/94", we_o, data_wr_o);
        end
      end
    end
    @(negedge clk); norm_we_i = '0; norm_addr_i = '0; norm_data_i = '0; #1;
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL drop_done done=%b busy=%b, required 1/0", done_o, busy_o); end
    bad = 0;
    for (int i = 0; i < N; i++) if (rmt[i] !== 7'(i * 3 + 1)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL drop_contents %0d entries wrong, rmt[2]=%0d required 7", bad, rmt[2]); end
  endtask

  initial begin
    test_reset();
    test_init_fill();
    test_passthrough();
    test_restore();
    test_pending();
    test_reset_abort();
    test_norm_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
